password_fsm: RTL and testbench

//   Four-digit keypad password checker for a board with four 7-segment displays.
//   - Digits are set on a 4-bit input and each one is committed with a "next" push-button.
//   - After the 4th digit the block shows OPEN (match) or FAIL (mismatch) on HEX3..HEX0.
//   - Top-level user-I/O block: switches/button in, segment drivers out.

---
 rtl/password_pkg.sv | 41 ++++
 rtl/password_fsm_seg7_hex.sv | 34 +++
 rtl/password_fsm.sv | 123 ++++++++++++
 tb/tb_password_fsm.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/password_pkg.sv
// rtl/password_pkg.sv - shared types and segment codes for the password checker
//
// Purpose: state encoding, active-low 7-segment symbol constants and a helper
//          that picks one digit out of the 16-bit password.
// Ports:   none (package).
package password_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_D1   = 3'd1,
    ST_D2   = 3'd2,
    ST_D3   = 3'd3,
    ST_OPEN = 3'd4,
    ST_FAIL = 3'd5
  } state_t;

  // Segment vectors are [0:6] = a..g, active-low, so the literal reads a..g left to right.
  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [0:6] SEG_DASH  = 7'b1111110;
  localparam logic [0:6] SEG_O     = 7'b0000001;
  localparam logic [0:6] SEG_P     = 7'b0011000;
  localparam logic [0:6] SEG_E     = 7'b0110000;
  localparam logic [0:6] SEG_N     = 7'b1101010;
  localparam logic [0:6] SEG_F     = 7'b0111000;
  localparam logic [0:6] SEG_A     = 7'b0001000;
  localparam logic [0:6] SEG_I     = 7'b1001111;
  localparam logic [0:6] SEG_L     = 7'b1110001;

  // Digit number 0..3 counts from the first entered digit, which lives in the top nibble.
  function automatic logic [3:0] password_nibble(input logic [15:0] pw, input logic [1:0] idx);
    logic [3:0] nib;
    case (idx)
      2'd0:    nib = pw[15:12];
      2'd1:    nib = pw[11:8];
      2'd2:    nib = pw[7:4];
      default: nib = pw[3:0];
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/password_fsm_seg7_hex.sv
// rtl/password_fsm_seg7_hex.sv - 4-bit value to active-low 7-segment hex decoder
//
// Purpose: drives the live-digit display with 0..9, A, b, C, d, E, F glyphs.
// Ports:   value [3:0] in  - nibble to show
//          seg   [0:6] out - segments a..g, active-low
module seg7_hex (
  input  logic [3:0] value,
  output logic [0:6] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (value)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/password_fsm.sv
// rtl/password_fsm.sv - four-digit keypad password checker with 7-segment display
//
// Purpose: digits on fsm_in are committed on each rising edge of next; after the
//          fourth digit the display shows OPEN on a match or FAIL otherwise.
// Ports:   clk                  in  - system clock
//          rst                  in  - synchronous active-high reset
//          next                 in  - push-button level, each 0->1 commits a digit
//          fsm_in    [4:1]      in  - digit being entered
//          fsm_out_0..3 [0:6]   out - HEX0..HEX3 segments, active-low, a..g
module password_fsm
  import password_pkg::*;
#(
  parameter logic [15:0] PASSWORD = 16'h1234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       next,
  input  logic [4:1] fsm_in,
  output logic [0:6] fsm_out_0,
  output logic [0:6] fsm_out_1,
  output logic [0:6] fsm_out_2,
  output logic [0:6] fsm_out_3
);

  state_t     state;
  logic       err;
  logic       next_q;
  logic       press;
  logic       digit_ok;
  logic [1:0] digit_idx;
  logic [0:6] live_seg;

  // next_q keeps following the button during reset so a push held across
  // reset release is not mistaken for a fresh press.
  assign press = next & ~next_q;

  always_comb begin
    digit_idx = 2'd3;
    case (state)
      ST_IDLE: digit_idx = 2'd0;
      ST_D1:   digit_idx = 2'd1;
      ST_D2:   digit_idx = 2'd2;
      default: digit_idx = 2'd3;
    endcase
  end

  assign digit_ok = (fsm_in == password_nibble(PASSWORD, digit_idx));

  always_ff @(posedge clk) begin
    next_q <= next;
    if (rst) begin
      state <= ST_IDLE;
      err   <= 1'b0;
    end else if (press) begin
      case (state)
        ST_IDLE: begin
          state <= ST_D1;
          err   <= ~digit_ok;
        end
        ST_D1: begin
          state <= ST_D2;
          err   <= err | ~digit_ok;
        end
        ST_D2: begin
          state <= ST_D3;
          err   <= err | ~digit_ok;
        end
        ST_D3: begin
          state <= (!err && digit_ok) ? ST_OPEN : ST_FAIL;
        end
        default: begin
          state <= ST_IDLE;
          err   <= 1'b0;
        end
      endcase
    end else if (state == ST_IDLE) begin
      err <= 1'b0;
    end
  end

  seg7_hex u_live_hex (
    .value (fsm_in),
    .seg   (live_seg)
  );

  // Display follows the registered state and the live digit combinationally.
  always_comb begin
    fsm_out_3 = SEG_BLANK;
    fsm_out_2 = SEG_BLANK;
    fsm_out_1 = SEG_BLANK;
    fsm_out_0 = live_seg;
    case (state)
      ST_D1: begin
        fsm_out_3 = SEG_DASH;
      end
      ST_D2: begin
        fsm_out_3 = SEG_DASH;
        fsm_out_2 = SEG_DASH;
      end
      ST_D3: begin
        fsm_out_3 = SEG_DASH;
        fsm_out_2 = SEG_DASH;
        fsm_out_1 = SEG_DASH;
      end
      ST_OPEN: begin
        fsm_out_3 = SEG_O;
        fsm_out_2 = SEG_P;
        fsm_out_1 = SEG_E;
        fsm_out_0 = SEG_N;
      end
      ST_FAIL: begin
        fsm_out_3 = SEG_F;
        fsm_out_2 = SEG_A;
        fsm_out_1 = SEG_I;
        fsm_out_0 = SEG_L;
      end
      default: begin
        fsm_out_3 = SEG_BLANK;
      end
    endcase
  end

endmodule

// File: tb/tb_password_fsm.sv
// tb/tb_password_fsm.sv - scoreboard bench for the password checker
module tb_password_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       next;
  logic [4:1] fsm_in;
  logic [0:6] fsm_out_0;
  logic [0:6] fsm_out_1;
  logic [0:6] fsm_out_2;
  logic [0:6] fsm_out_3;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [27:0] val;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [6:0] B  = 7'b1111111;
  localparam logic [6:0] DS = 7'b1111110;
  localparam logic [27:0] DISP_OPEN = {7'b0000001, 7'b0011000, 7'b0110000, 7'b1101010};
  localparam logic [27:0] DISP_FAIL = {7'b0111000, 7'b0001000, 7'b1001111, 7'b1110001};

  logic [6:0] hex_tab [16];

  password_fsm #(.PASSWORD(16'h1234)) dut (
    .clk       (clk),
    .rst       (rst),
    .next      (next),
    .fsm_in    (fsm_in),
    .fsm_out_0 (fsm_out_0),
    .fsm_out_1 (fsm_out_1),
    .fsm_out_2 (fsm_out_2),
    .fsm_out_3 (fsm_out_3)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b_%b_%b_%b expected %b_%b_%b_%b", tag,
               obs[27:21], obs[20:14], obs[13:7], obs[6:0],
               exp[27:21], exp[20:14], exp[13:7], exp[6:0]);
    end
  endtask

  // Expected display while entering: n dashes from HEX3 downward, live digit on HEX0.
  function automatic logic [27:0] entry_disp(input int n, input logic [3:0] d);
    return {(n >= 1) ? DS : B, (n >= 2) ? DS : B, (n >= 3) ? DS : B, hex_tab[d]};
  endfunction

  task automatic expect_disp(input string tag, input logic [27:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // Called on a negative edge, away from the active edge.
  task automatic compare_next();
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 28'h0, 28'h1);
    end else begin
      e = exp_q.pop_front();
      check_val(e.tag, {fsm_out_3, fsm_out_2, fsm_out_1, fsm_out_0}, e.val);
    end
  endtask

  task automatic press(input logic [3:0] d);
    @(negedge clk);
    fsm_in = d;
    next   = 1'b1;
    @(negedge clk);
    next   = 1'b0;
  endtask

  task automatic press_and_check(input string tag, input logic [3:0] d, input logic [27:0] val);
    expect_disp(tag, val);
    press(d);
    compare_next();
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    hex_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    rst    = 1'b1;
    next   = 1'b0;
    fsm_in = 4'h0;

    do_reset(2);
    expect_disp("reset_idle", {B, B, B, 7'b0000001});
    compare_next();

    // live digit in IDLE, boundary value F
    @(negedge clk);
    fsm_in = 4'hF;
    #1;
    expect_disp("idle_live_F", entry_disp(0, 4'hF));
    compare_next();

    // correct code
    press_and_check("ok_d1", 4'h1, entry_disp(1, 4'h1));
    press_and_check("ok_d2", 4'h2, entry_disp(2, 4'h2));
    press_and_check("ok_d3", 4'h3, entry_disp(3, 4'h3));
    press_and_check("ok_open", 4'h4, DISP_OPEN);
    repeat (3) @(negedge clk);
    expect_disp("open_hold", DISP_OPEN);
    compare_next();

    // restart from OPEN, then reversed code
    press_and_check("restart_idle", 4'h7, entry_disp(0, 4'h7));
    press_and_check("rev_d1", 4'h4, entry_disp(1, 4'h4));
    press_and_check("rev_d2", 4'h3, entry_disp(2, 4'h3));
    press_and_check("rev_d3", 4'h2, entry_disp(3, 4'h2));
    press_and_check("rev_fail", 4'h1, DISP_FAIL);

    // wrong second digit: still only dashes until the end
    press_and_check("fail_to_idle", 4'h0, entry_disp(0, 4'h0));
    press_and_check("wrong_d1", 4'h1, entry_disp(1, 4'h1));
    press_and_check("wrong_d2_dash", 4'h5, entry_disp(2, 4'h5));
    press_and_check("wrong_d3", 4'h3, entry_disp(3, 4'h3));
    press_and_check("wrong_fail", 4'h4, DISP_FAIL);

    // mismatch only in the last digit
    press_and_check("fail_to_idle2", 4'h0, entry_disp(0, 4'h0));
    press(4'h1);
    press(4'h2);
    press(4'h3);
    press_and_check("last_wrong_fail", 4'h5, DISP_FAIL);

    // mismatch only in the first digit
    press_and_check("fail_to_idle3", 4'h0, entry_disp(0, 4'h0));
    press(4'h0);
    press(4'h2);
    press(4'h3);
    press_and_check("first_wrong_fail", 4'h4, DISP_FAIL);

    // held button commits exactly one digit
    press_and_check("fail_to_idle4", 4'h0, entry_disp(0, 4'h0));
    @(negedge clk);
    fsm_in = 4'h1;
    next   = 1'b1;
    repeat (5) @(negedge clk);
    next   = 1'b0;
    expect_disp("held_one_digit", entry_disp(1, 4'h1));
    compare_next();
    press_and_check("held_then_d2", 4'h2, entry_disp(2, 4'h2));

    // reset mid-entry discards digits, then correct code opens
    do_reset(1);
    expect_disp("midreset_idle", entry_disp(0, 4'h2));
    compare_next();
    press(4'h1);
    press(4'h2);
    press(4'h3);
    press_and_check("after_reset_open", 4'h4, DISP_OPEN);

    // button held across reset release is not a press
    @(negedge clk);
    fsm_in = 4'h1;
    rst    = 1'b1;
    next   = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    repeat (2) @(negedge clk);
    expect_disp("held_through_reset", entry_disp(0, 4'h1));
    compare_next();
    next = 1'b0;
    press_and_check("after_held_reset_d1", 4'h1, entry_disp(1, 4'h1));

    if (exp_q.size() != 0) check_val("scoreboard_leftover", 28'(exp_q.size()), 28'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
